buf_pool_manager: RTL and testbench

//  Wishbone-slave free-list allocator for NBUFS buffer IDs. Next generation of the buffer manager.

---
 rtl/buf_pool_manager_pkg.sv | 18 +
 rtl/buf_pool_manager_if.sv | 23 ++
 rtl/buf_pool_manager_id_fifo.sv | 54 +++++
 rtl/buf_pool_manager.sv | 159 +++++++++++++++
 tb/tb_buf_pool_manager.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buf_pool_manager_pkg.sv
// Shared definitions for the buffer pool manager: register offsets, STATUS bit
// positions and FSM state encoding.
package buf_pool_manager_pkg;

   localparam logic [1:0] REG_ALLOC   = 2'd0;
   localparam logic [1:0] REG_FREE    = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_LOWMARK = 2'd3;

   localparam int STATUS_EMPTY_BIT = 16;
   localparam int STATUS_ERR_BIT   = 17;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } pool_state_t;

endpackage

// File: rtl/buf_pool_manager_if.sv
// Wishbone slave bus bundle between the system bus and the buffer pool manager.
interface buf_pool_manager_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] wbs_address;
   logic [DATA_WIDTH-1:0] wbs_writedata;
   logic [DATA_WIDTH-1:0] wbs_readdata;
   logic                  wbs_strobe;
   logic                  wbs_cycle;
   logic                  wbs_write;
   logic                  wbs_ack;

   modport master (
      output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
      input  wbs_readdata, wbs_ack
   );

   modport slave (
      input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write,
      output wbs_readdata, wbs_ack
   );
endinterface

// File: rtl/buf_pool_manager_id_fifo.sv
// Show-ahead free-list FIFO of buffer IDs; depth NBUFS need not be a power of two,
// so pointers wrap explicitly at NBUFS-1.
module buf_id_fifo #(
   parameter int NBUFS    = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [ID_WIDTH-1:0] push_data,
   input  logic                pop,
   output logic [ID_WIDTH-1:0] head,
   output logic                empty,
   output logic                full,
   output logic [ID_WIDTH:0]   count
);

   logic [ID_WIDTH-1:0] mem [NBUFS];
   logic [ID_WIDTH-1:0] rd_ptr;
   logic [ID_WIDTH-1:0] wr_ptr;
   logic                push_ok;
   logic                pop_ok;

   function automatic logic [ID_WIDTH-1:0] ptr_next(input logic [ID_WIDTH-1:0] p);
      return (p == ID_WIDTH'(NBUFS - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == (ID_WIDTH+1)'(NBUFS));
   assign head    = mem[rd_ptr];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_next(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/buf_pool_manager.sv
// Wishbone free-list allocator for NBUFS buffer IDs with low-watermark interrupt.
// Define BUF_POOL_DFREE_CHECK_EN to reject frees of IDs that are not allocated.
module buf_pool_manager
   import buf_pool_manager_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int NBUFS      = 4,
   parameter int ID_WIDTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   buf_pool_manager_if.slave  wb,
   output logic               irq_low
);

   pool_state_t           state;
   logic [ID_WIDTH-1:0]   init_id;
   logic                  ack_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic                  err;
   logic [15:0]           lowmark;

   logic                  push;
   logic [ID_WIDTH-1:0]   push_data;
   logic                  pop;
   logic [ID_WIDTH-1:0]   head;
   logic                  empty;
   logic                  full;
   logic [ID_WIDTH:0]     free_cnt;
   logic [ID_WIDTH:0]     free_cnt_next;

   logic [1:0]            reg_sel;
   logic                  accept;
   logic [ID_WIDTH-1:0]   free_id;
   logic                  free_ok;
   logic [DATA_WIDTH-1:0] rd_val;
   logic                  addr_unused;

`ifdef BUF_POOL_DFREE_CHECK_EN
   logic [NBUFS-1:0]      in_use;
`endif

   buf_id_fifo #(
      .NBUFS    (NBUFS),
      .ID_WIDTH (ID_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (empty),
      .full      (full),
      .count     (free_cnt)
   );

   assign reg_sel          = wb.wbs_address[3:2];
   assign addr_unused      = ^{wb.wbs_address[ADDR_WIDTH-1:4], wb.wbs_address[1:0]};
   assign accept           = (state == ST_IDLE) & wb.wbs_cycle & wb.wbs_strobe & ~ack_r;
   assign free_id          = wb.wbs_writedata[ID_WIDTH-1:0];
   assign wb.wbs_ack       = ack_r & wb.wbs_cycle & wb.wbs_strobe;
   assign wb.wbs_readdata  = rdata_r;

   // Range check uses the full write word so stray upper bits cannot alias a valid ID.
`ifdef BUF_POOL_DFREE_CHECK_EN
   assign free_ok = (wb.wbs_writedata < DATA_WIDTH'(NBUFS)) & ~full & in_use[free_id];
`else
   assign free_ok = (wb.wbs_writedata < DATA_WIDTH'(NBUFS)) & ~full;
`endif

   always_comb begin
      push      = 1'b0;
      push_data = init_id;
      pop       = 1'b0;
      if (state == ST_INIT) begin
         push = 1'b1;
      end else if (accept) begin
         if (wb.wbs_write && reg_sel == REG_FREE && free_ok) begin
            push      = 1'b1;
            push_data = free_id;
         end
         if (!wb.wbs_write && reg_sel == REG_ALLOC && !empty) pop = 1'b1;
      end
   end

   always_comb begin
      free_cnt_next = free_cnt;
      if (push)     free_cnt_next = free_cnt + 1'b1;
      else if (pop) free_cnt_next = free_cnt - 1'b1;
   end

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_ALLOC:  rd_val = empty ? '1 : DATA_WIDTH'(head);
         REG_STATUS: begin
            rd_val[15:0]             = 16'(free_cnt);
            rd_val[STATUS_EMPTY_BIT] = empty;
            rd_val[STATUS_ERR_BIT]   = err;
         end
         REG_LOWMARK: rd_val[15:0] = lowmark;
         default:     rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_INIT;
         init_id <= '0;
         ack_r   <= 1'b0;
         rdata_r <= '0;
         err     <= 1'b0;
         lowmark <= '0;
         irq_low <= 1'b0;
      end else begin
         ack_r   <= accept;
         irq_low <= (state == ST_IDLE) && (32'(free_cnt_next) < 32'(lowmark));
         case (state)
            ST_INIT: begin
               if (init_id == ID_WIDTH'(NBUFS - 1)) begin
                  state   <= ST_IDLE;
                  init_id <= '0;
               end else begin
                  init_id <= init_id + 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  if (!wb.wbs_write) begin
                     rdata_r <= rd_val;
                  end else begin
                     case (reg_sel)
                        REG_FREE:    if (!free_ok) err <= 1'b1;
                        REG_STATUS:  if (wb.wbs_writedata[STATUS_ERR_BIT]) err <= 1'b0;
                        REG_LOWMARK: lowmark <= wb.wbs_writedata[15:0];
                        default:     ;
                     endcase
                  end
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

`ifdef BUF_POOL_DFREE_CHECK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_use <= '0;
      end else begin
         if (pop) in_use[head] <= 1'b1;
         else if (push && state == ST_IDLE) in_use[push_data] <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_buf_pool_manager.sv
// Directed self-checking bench for buf_pool_manager (NBUFS=4).
module tb_buf_pool_manager;
   import buf_pool_manager_pkg::*;

   localparam int NBUFS = 4;

   logic clk;
   logic reset;
   logic irq_low;
   int   checks;
   int   errors;

   buf_pool_manager_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) wb ();

   buf_pool_manager #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (32),
      .NBUFS      (NBUFS),
      .ID_WIDTH   (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wb      (wb),
      .irq_low (irq_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus(input logic wr, input logic [1:0] sel, input logic [31:0] wd,
                      output logic [31:0] rd);
      logic got;
      got = 1'b0;
      rd  = 32'hDEAD_BEEF;
      @(negedge clk);
      wb.wbs_address   = {12'h000, sel, 2'b00};
      wb.wbs_writedata = wd;
      wb.wbs_write     = wr;
      wb.wbs_cycle     = 1'b1;
      wb.wbs_strobe    = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (wb.wbs_ack) begin
            got = 1'b1;
            rd  = wb.wbs_readdata;
         end
      end
      wb.wbs_cycle  = 1'b0;
      wb.wbs_strobe = 1'b0;
      wb.wbs_write  = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bus_timeout sel=%0d ack never seen, required within 20 cycles", sel);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (NBUFS + 2) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (wb.wbs_ack !== 1'b0 || wb.wbs_readdata !== 32'h0 || irq_low !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs ack=%b rdata=%h irq=%b, required 0 0 0",
                  wb.wbs_ack, wb.wbs_readdata, irq_low);
      end
      reset = 1'b0;
      repeat (NBUFS + 2) @(negedge clk);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0004) begin
         errors++;
         $display("FAIL reset_status got %h, required 00000004", rd);
      end
   endtask

   task automatic test_alloc();
      logic [31:0] rd;
      for (int i = 0; i < NBUFS; i++) begin
         bus(1'b0, REG_ALLOC, 32'h0, rd);
         checks++;
         if (rd !== 32'(i)) begin
            errors++;
            $display("FAIL alloc_seq[%0d] got %h, required %h", i, rd, 32'(i));
         end
      end
   endtask

   task automatic test_empty();
      logic [31:0] rd;
      bus(1'b0, REG_ALLOC, 32'h0, rd);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL alloc_empty got %h, required ffffffff", rd);
      end
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0001_0000) begin
         errors++;
         $display("FAIL status_empty got %h, required 00010000", rd);
      end
      bus(1'b1, REG_FREE, 32'd2, rd);
      bus(1'b0, REG_ALLOC, 32'h0, rd);
      checks++;
      if (rd !== 32'd2) begin
         errors++;
         $display("FAIL alloc_after_free got %h, required 00000002", rd);
      end
   endtask

   task automatic test_free_errors();
      logic [31:0] rd;
      bus(1'b1, REG_FREE, 32'd7, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0003_0000) begin
         errors++;
         $display("FAIL free_range_err got %h, required 00030000", rd);
      end
      bus(1'b1, REG_STATUS, 32'h0002_0000, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0001_0000) begin
         errors++;
         $display("FAIL err_clear got %h, required 00010000", rd);
      end
      bus(1'b1, REG_FREE, 32'h0000_0104, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0003_0000) begin
         errors++;
         $display("FAIL free_upper_bits got %h, required 00030000", rd);
      end
      do_reset();
      bus(1'b1, REG_FREE, 32'd3, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0002_0004) begin
         errors++;
         $display("FAIL free_when_full got %h, required 00020004", rd);
      end
   endtask

   task automatic test_lowmark_irq();
      logic [31:0] rd;
      do_reset();
      bus(1'b1, REG_LOWMARK, 32'hABCD_0002, rd);
      bus(1'b0, REG_LOWMARK, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("FAIL lowmark_read got %h, required 00000002", rd);
      end
      for (int i = 0; i < 3; i++) begin
         bus(1'b0, REG_ALLOC, 32'h0, rd);
         checks++;
         if (irq_low !== (i == 2)) begin
            errors++;
            $display("FAIL irq_after_alloc[%0d] got %b, required %b", i, irq_low, (i == 2));
         end
      end
      bus(1'b1, REG_FREE, 32'd1, rd);
      checks++;
      if (irq_low !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_free got %b, required 0", irq_low);
      end
      bus(1'b0, REG_FREE, 32'h0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL free_read got %h, required 00000000", rd);
      end
      bus(1'b1, REG_ALLOC, 32'h0, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0002) begin
         errors++;
         $display("FAIL alloc_write_ignored got %h, required 00000002", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_ack;
      int   n;
      do_reset();
      n = 0;
      @(negedge clk);
      wb.wbs_address = {12'h000, REG_ALLOC, 2'b00};
      wb.wbs_write   = 1'b0;
      wb.wbs_cycle   = 1'b1;
      wb.wbs_strobe  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         exp_ack = (i % 2 == 1);
         checks++;
         if (wb.wbs_ack !== exp_ack) begin
            errors++;
            $display("FAIL b2b_ack[%0d] got %b, required %b", i, wb.wbs_ack, exp_ack);
         end
         if (exp_ack) begin
            checks++;
            if (wb.wbs_readdata !== 32'(n)) begin
               errors++;
               $display("FAIL b2b_data[%0d] got %h, required %h", n, wb.wbs_readdata, 32'(n));
            end
            n++;
         end
      end
      wb.wbs_cycle  = 1'b0;
      wb.wbs_strobe = 1'b0;
   endtask

   task automatic test_init_block();
      int first_ack;
      first_ack = -1;
      @(negedge clk);
      reset = 1'b1;
      wb.wbs_address = {12'h000, REG_ALLOC, 2'b00};
      wb.wbs_write   = 1'b0;
      wb.wbs_cycle   = 1'b1;
      wb.wbs_strobe  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 20 && first_ack < 0; k++) begin
         @(negedge clk);
         if (wb.wbs_ack) first_ack = k;
      end
      checks++;
      if (first_ack != NBUFS + 1 || wb.wbs_readdata !== 32'h0) begin
         errors++;
         $display("FAIL init_block first ack at %0d data %h, required %0d data 00000000",
                  first_ack, wb.wbs_readdata, NBUFS + 1);
      end
      wb.wbs_cycle  = 1'b0;
      wb.wbs_strobe = 1'b0;
   endtask

   task automatic test_reset_mid_ack();
      logic [31:0] rd;
      logic        got;
      got = 1'b0;
      @(negedge clk);
      wb.wbs_address = {12'h000, REG_ALLOC, 2'b00};
      wb.wbs_write   = 1'b0;
      wb.wbs_cycle   = 1'b1;
      wb.wbs_strobe  = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = wb.wbs_ack;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (!got || wb.wbs_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_ack ack_seen=%b ack_after_reset=%b, required 1 0", got, wb.wbs_ack);
      end
      wb.wbs_cycle  = 1'b0;
      wb.wbs_strobe = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (NBUFS + 2) @(negedge clk);
      bus(1'b0, REG_STATUS, 32'h0, rd);
      checks++;
      if (rd !== 32'h0000_0004) begin
         errors++;
         $display("FAIL reinit_status got %h, required 00000004", rd);
      end
   endtask

   task automatic test_double_free();
      logic [31:0] rd;
      logic [31:0] exp;
      do_reset();
      bus(1'b0, REG_ALLOC, 32'h0, rd);
      bus(1'b0, REG_ALLOC, 32'h0, rd);
      bus(1'b1, REG_FREE, 32'd0, rd);
      bus(1'b1, REG_FREE, 32'd0, rd);
      bus(1'b0, REG_STATUS, 32'h0, rd);
`ifdef BUF_POOL_DFREE_CHECK_EN
      exp = 32'h0002_0003;
`else
      exp = 32'h0000_0004;
`endif
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL double_free_status got %h, required %h", rd, exp);
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b1;
      wb.wbs_address   = '0;
      wb.wbs_writedata = '0;
      wb.wbs_write     = 1'b0;
      wb.wbs_cycle     = 1'b0;
      wb.wbs_strobe    = 1'b0;
      test_reset();
      test_alloc();
      test_empty();
      test_free_errors();
      test_lowmark_irq();
      test_back_to_back();
      test_init_block();
      test_reset_mid_ack();
      test_double_free();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
